rv_mem_arb: RTL



---
 rtl/rv_mem_arb_if.sv | 30 +++
 rtl/rv_mem_arb.sv | 126 ++++++++++++
 2 files changed

// File: rtl/rv_mem_arb_if.sv
// rtl/rv_mem_arb_if.sv - core-side request ports and memory-side bus of the arbiter
interface rv_mem_arb_if;
  logic [31:0] i_adr;
  logic        i_re;
  logic [31:0] i_dr;
  logic        i_rdy;
  logic [31:0] d_adr;
  logic        d_re;
  logic [31:0] d_dw;
  logic [3:0]  d_we;
  logic [31:0] d_dr;
  logic        d_rdy;
  logic        m_req;
  logic [31:0] m_adr;
  logic [3:0]  m_we;
  logic [31:0] m_dw;
  logic [31:0] m_dr;
  logic        m_ack;
  logic        err;

  modport slave (
    input  i_adr, i_re, d_adr, d_re, d_dw, d_we, m_dr, m_ack,
    output i_dr, i_rdy, d_dr, d_rdy, m_req, m_adr, m_we, m_dw, err
  );

  modport master (
    output i_adr, i_re, d_adr, d_re, d_dw, d_we, m_dr, m_ack,
    input  i_dr, i_rdy, d_dr, d_rdy, m_req, m_adr, m_we, m_dw, err
  );
endinterface

// File: rtl/rv_mem_arb.sv
// rtl/rv_mem_arb.sv - single-port memory arbiter for instruction/data requests
// Data access is always issued before instruction access; both sides complete together in DONE.
module rv_mem_arb #(
  parameter int          TMO    = 255,
  parameter logic [31:0] MTBASE = 32'hffff8000
) (
  input logic          clk,
  input logic          xreset,
  rv_mem_arb_if.slave  bus
);
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, DACC, IACC, DONE} state_t;

  state_t      state, state_nx;
  logic        ilat;
  logic [31:0] dadr_q, ddw_q, iadr_q;
  logic [3:0]  dwe_q;
  logic [31:0] dhold, ihold;
  logic [31:0] i_dr_q, d_dr_q;
  logic        err_q;
  logic [CW-1:0] cnt;

  logic dreq, ireq, in_mt, tmo_hit, fin;

  assign dreq    = bus.d_re | (bus.d_we != 4'b0000);
  assign ireq    = bus.i_re;
  // Unsigned difference wraps for addresses below the window, so one compare covers both ends.
  assign in_mt   = (bus.d_adr - MTBASE) < 32'd16;
  assign tmo_hit = (cnt == CW'(TMO - 1));
  assign fin     = bus.m_ack | tmo_hit;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (dreq && !in_mt) state_nx = DACC;
        else if (ireq)      state_nx = IACC;
        else if (dreq)      state_nx = DONE;
      end
      DACC:    if (fin) state_nx = ilat ? IACC : DONE;
      IACC:    if (fin) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.m_req = 1'b0;
    bus.m_adr = 32'd0;
    bus.m_we  = 4'b0000;
    bus.m_dw  = 32'd0;
    case (state)
      DACC: begin
        bus.m_req = 1'b1;
        bus.m_adr = dadr_q & ~32'h3;
        bus.m_we  = dwe_q;
        bus.m_dw  = ddw_q;
      end
      IACC: begin
        bus.m_req = 1'b1;
        bus.m_adr = iadr_q & ~32'h3;
      end
      default: ;
    endcase
  end

  assign bus.i_rdy = (state == DONE);
  assign bus.d_rdy = (state == DONE);
  assign bus.i_dr  = i_dr_q;
  assign bus.d_dr  = d_dr_q;
  assign bus.err   = err_q;

  always_ff @(posedge clk) begin
    if (!xreset) begin
      state  <= IDLE;
      ilat   <= 1'b0;
      dadr_q <= 32'd0;
      ddw_q  <= 32'd0;
      dwe_q  <= 4'b0000;
      iadr_q <= 32'd0;
      dhold  <= 32'd0;
      ihold  <= 32'd0;
      i_dr_q <= 32'd0;
      d_dr_q <= 32'd0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          ilat   <= ireq;
          dadr_q <= bus.d_adr;
          ddw_q  <= bus.d_dw;
          dwe_q  <= bus.d_we;
          iadr_q <= bus.i_adr;
          cnt    <= '0;
          if (dreq && in_mt) dhold <= 32'd0;
        end
        DACC: begin
          if (fin) begin
            cnt <= '0;
            if (!bus.m_ack)              dhold <= 32'hdeadbeef;
            else if (dwe_q != 4'b0000)   dhold <= 32'd0;
            else                         dhold <= bus.m_dr;
            if (!bus.m_ack) err_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        IACC: begin
          if (fin) begin
            cnt   <= '0;
            ihold <= bus.m_ack ? bus.m_dr : 32'hdeadbeef;
            if (!bus.m_ack) err_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          i_dr_q <= ihold;
          d_dr_q <= dhold;
        end
      endcase
    end
  end
endmodule
